// File: rtl/div64_share_arb.sv
// div64_share_arb: round-robin arbiter sharing one 64-bit divider among four requesters
module div64_share_arb #(
    parameter int NREQ = 4,
    parameter int TAGW = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*64-1:0] req_in1,
    input  logic [NREQ*64-1:0] req_in2,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [NREQ*64-1:0] rsp_quotient,
    output logic [NREQ*64-1:0] rsp_remainder,
    output logic [NREQ-1:0]    rsp_div_by_zero,
    input  logic               stall,
    output logic               busy,
    output logic               err,
    output logic [63:0]        div_in1,
    output logic [63:0]        div_in2,
    output logic [TAGW-1:0]    div_in_usr,
    output logic               div_in_en,
    output logic               div_stop,
    input  logic [63:0]        div_quotient,
    input  logic [63:0]        div_remainder,
    input  logic [TAGW-1:0]    div_out_usr,
    input  logic               div_div_by_zero,
    input  logic               div_out_en
);
    logic [NREQ-1:0]   outstanding, elig;
    logic [2*NREQ-1:0] rot;
    logic [1:0]        rr_ptr, off, gnt_id, rid;
    logic              gnt_vld, res_ok, res_bad;
    // gating with reset keeps req_ready low while reset is asserted
    assign elig = req_valid & ~outstanding & ~rsp_valid & {NREQ{reset & ~stall}};
    assign rot = {elig, elig} >> rr_ptr;
    always_comb begin
        off = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) off = rot[k] ? 2'(k) : off;
    end
    assign gnt_vld    = |elig;
    assign gnt_id     = rr_ptr + off;
    assign req_ready  = {NREQ{gnt_vld}} & (NREQ'(1) << gnt_id);
    assign div_in_en  = gnt_vld;
    assign div_in1    = gnt_vld ? req_in1[{gnt_id, 6'd0} +: 64] : '0;
    assign div_in2    = gnt_vld ? req_in2[{gnt_id, 6'd0} +: 64] : '0;
    assign div_in_usr = gnt_vld ? TAGW'(gnt_id) : '0;
    assign div_stop   = stall;
    assign busy       = |outstanding;
    assign rid        = div_out_usr[1:0];
    assign res_ok     = div_out_en & outstanding[rid] & ~|div_out_usr[TAGW-1:2];
    assign res_bad    = div_out_en & ~res_ok;
    always_ff @(posedge clock) begin
        if (!reset) begin
            outstanding     <= '0;
            rsp_valid       <= '0;
            rsp_quotient    <= '0;
            rsp_remainder   <= '0;
            rsp_div_by_zero <= '0;
            rr_ptr          <= 2'd0;
            err             <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid & ~rsp_ready;
            if (gnt_vld) begin
                outstanding[gnt_id] <= 1'b1;
                rr_ptr              <= gnt_id + 2'd1;
            end
            if (res_ok) begin
                outstanding[rid]                  <= 1'b0;
                rsp_valid[rid]                    <= 1'b1;
                rsp_quotient[{rid, 6'd0} +: 64]   <= div_quotient;
                rsp_remainder[{rid, 6'd0} +: 64]  <= div_remainder;
                rsp_div_by_zero[rid]              <= div_div_by_zero;
            end
            if (res_bad) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_div64_share_arb.sv
// tb_div64_share_arb: directed tests with a fixed-latency divider and a request-level scoreboard
module tb_div64_share_arb;
    localparam int L = 3;
    logic         clock = 1'b0, reset = 1'b0, stall = 1'b0;
    logic [3:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = 4'hF, rsp_div_by_zero;
    logic [255:0] req_in1 = '0, req_in2 = '0, rsp_quotient, rsp_remainder;
    logic         busy, err, div_in_en, div_stop, div_div_by_zero, div_out_en;
    logic [63:0]  div_in1, div_in2, div_quotient, div_remainder;
    logic [4:0]   div_in_usr, div_out_usr;
    logic         inj = 1'b0;
    logic [4:0]   inj_usr = '0;
    int total = 0, bad = 0;

    always #5 clock = ~clock;

    div64_share_arb dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div_by_zero(rsp_div_by_zero), .stall(stall), .busy(busy), .err(err),
        .div_in1(div_in1), .div_in2(div_in2), .div_in_usr(div_in_usr), .div_in_en(div_in_en),
        .div_stop(div_stop), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_out_usr(div_out_usr), .div_div_by_zero(div_div_by_zero), .div_out_en(div_out_en)
    );

    // shared divider: fixed latency, result strobe L cycles after issue
    logic        pv[L], pz[L];
    logic [63:0] pq[L], pr[L];
    logic [4:0]  pu[L];
    always @(posedge clock) begin
        pv[0] <= reset & div_in_en;
        pu[0] <= div_in_usr;
        pz[0] <= (div_in2 == 0);
        pq[0] <= (div_in2 == 0) ? '1 : div_in1 / div_in2;
        pr[0] <= (div_in2 == 0) ? div_in1 : div_in1 % div_in2;
        for (int k = 1; k < L; k++) begin
            pv[k] <= reset & pv[k-1];
            pu[k] <= pu[k-1];
            pz[k] <= pz[k-1];
            pq[k] <= pq[k-1];
            pr[k] <= pr[k-1];
        end
    end
    assign div_out_en      = inj | pv[L-1];
    assign div_out_usr     = inj ? inj_usr : pu[L-1];
    assign div_quotient    = pq[L-1];
    assign div_remainder   = pr[L-1];
    assign div_div_by_zero = pz[L-1];

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // scoreboard: per-requester request state plus last granted requester
    bit          m_init = 0, m_err = 0;
    bit          m_out[4], m_rv[4], m_z[4];
    logic [63:0] m_a[4], m_b[4], m_q[4], m_r[4];
    int          m_last = 3;

    function automatic int exp_grant();
        int i;
        if (!m_init || !reset || stall) return -1;
        for (int k = 1; k <= 4; k++) begin
            i = (m_last + k) % 4;
            if (req_valid[i] && !m_out[i] && !m_rv[i]) return i;
        end
        return -1;
    endfunction

    // inputs are stable from posedge+1 until the next edge, so the negedge sees what that edge will sample
    always @(negedge clock) begin
        int g, ga, id;
        logic [255:0] eq, erm;
        logic [3:0] ev, ez;
        bit any;
        g = exp_grant();
        ga = (g < 0) ? 0 : g;
        if (m_init) begin
            any = 0;
            for (int i = 0; i < 4; i++) begin
                eq[i*64 +: 64] = m_q[i];
                erm[i*64 +: 64] = m_r[i];
                ev[i] = m_rv[i];
                ez[i] = m_z[i];
                any |= m_out[i];
            end
            chk("req_ready", req_ready, (g < 0) ? 4'd0 : 4'(1 << g));
            chk("div_in_en", div_in_en, g >= 0);
            chk("div_in1", div_in1, (g < 0) ? 64'd0 : req_in1[ga*64 +: 64]);
            chk("div_in2", div_in2, (g < 0) ? 64'd0 : req_in2[ga*64 +: 64]);
            chk("div_in_usr", div_in_usr, (g < 0) ? 5'd0 : 5'(ga));
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_quotient", rsp_quotient, eq);
            chk("rsp_remainder", rsp_remainder, erm);
            chk("rsp_dbz", rsp_div_by_zero, ez);
            chk("busy", busy, any);
            chk("err", err, m_err);
            chk("div_stop", div_stop, stall);
        end
        if (!reset) begin
            m_init = 1; m_err = 0; m_last = 3;
            for (int i = 0; i < 4; i++) begin
                m_out[i] = 0; m_rv[i] = 0; m_z[i] = 0; m_q[i] = 0; m_r[i] = 0;
            end
        end else if (m_init) begin
            for (int i = 0; i < 4; i++) if (m_rv[i] && rsp_ready[i]) m_rv[i] = 0;
            if (div_out_en) begin
                id = int'(div_out_usr[1:0]);
                if (m_out[id] && div_out_usr[4:2] == 0) begin
                    m_out[id] = 0;
                    m_rv[id] = 1;
                    m_z[id] = (m_b[id] == 0);
                    m_q[id] = (m_b[id] == 0) ? '1 : m_a[id] / m_b[id];
                    m_r[id] = (m_b[id] == 0) ? m_a[id] : m_a[id] % m_b[id];
                end else m_err = 1;
            end
            if (g >= 0) begin
                m_out[g] = 1;
                m_a[g] = req_in1[g*64 +: 64];
                m_b[g] = req_in2[g*64 +: 64];
                m_last = g;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(input int i, output logic [4:0] usr);
        bit got = 0;
        usr = '1;
        for (int n = 0; n < 50 && !got; n++) begin
            #1;
            if (req_ready[i]) begin
                got = 1;
                usr = div_in_usr;
            end
            tick();
        end
        req_valid[i] = 1'b0;
        chk("grant_seen", got, 1);
    endtask

    task automatic wait_rsp(input int i);
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            #1;
            if (rsp_valid[i]) got = 1;
            else tick();
        end
        chk("rsp_seen", got, 1);
    endtask

    task automatic grab_order(output logic [3:0] ord[4]);
        for (int k = 0; k < 4; k++) begin
            #1;
            ord[k] = req_ready;
            tick();
        end
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] usr;
        logic [3:0] ord[4];
        int cnt2, cnto;
        req_in1 = {64'd4003, 64'd77, 64'd2001, 64'd100};
        req_in2 = {64'd6, 64'd10, 64'd4, 64'd7};
        tick(); tick(); tick();
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        tick();

        req_valid[0] = 1'b1;
        wait_grant(0, usr);
        chk("t1_usr", usr, 0);
        wait_rsp(0);
        chk("t1_quot", rsp_quotient[63:0], 14);
        chk("t1_rem", rsp_remainder[63:0], 2);
        chk("t1_dbz", rsp_div_by_zero[0], 0);
        repeat (4) tick();

        reset = 1'b0;
        req_valid = 4'hF;
        tick(); tick();
        reset = 1'b1;
        grab_order(ord);
        chk("t2_ord0", ord[0], 4'b0001);
        chk("t2_ord1", ord[1], 4'b0010);
        chk("t2_ord2", ord[2], 4'b0100);
        chk("t2_ord3", ord[3], 4'b1000);
        repeat (12) tick();

        rsp_ready = 4'b1011;
        req_valid = 4'hF;
        cnt2 = 0;
        cnto = 0;
        repeat (20) begin
            #1;
            if (req_ready[2]) cnt2++;
            else if (req_ready != 0) cnto++;
            tick();
        end
        req_valid = '0;
        chk("t3_grants2", cnt2, 1);
        chk("t3_others", cnto > 0, 1);
        chk("t3_held", rsp_valid[2], 1);
        chk("t3_quot", rsp_quotient[191:128], 7);
        chk("t3_rem", rsp_remainder[191:128], 7);
        rsp_ready = 4'hF;
        repeat (12) tick();

        req_in1[127:64] = 64'd5;
        req_in2[127:64] = 64'd0;
        req_valid[1] = 1'b1;
        wait_grant(1, usr);
        chk("t4_usr", usr, 1);
        wait_rsp(1);
        chk("t4_dbz", rsp_div_by_zero[1], 1);
        chk("t4_err", err, 0);
        repeat (8) tick();

        stall = 1'b1;
        req_valid = 4'hF;
        repeat (10) begin
            #1;
            chk("t5_ready", req_ready, 0);
            chk("t5_stop", div_stop, 1);
            tick();
        end
        stall = 1'b0;
        grab_order(ord);
        chk("t5_ord0", ord[0], 4'b0100);
        chk("t5_ord1", ord[1], 4'b1000);
        chk("t5_ord2", ord[2], 4'b0001);
        chk("t5_ord3", ord[3], 4'b0010);
        repeat (12) tick();

        inj = 1'b1;
        inj_usr = 5'd3;
        tick();
        inj = 1'b0;
        #1;
        chk("t6_err", err, 1);
        repeat (3) begin
            chk("t6_no_rsp3", rsp_valid[3], 0);
            tick();
        end
        chk("t6_err_hold", err, 1);
        reset = 1'b0;
        tick();
        #1;
        chk("t6_err_clr", err, 0);
        reset = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
